// File: rtl/edge_detect_stream.sv
// Streaming 3x3 gradient-magnitude edge detector: 4 kernels, optional binarisation, per-frame edge count.
// Latency: 3 advancing cycles from input handshake to out_valid; sustains 1 beat/cycle with out_ready high.
// Backpressure: all stages advance together only when the output register is empty or draining; in_ready mirrors that.
module edge_detect_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              cfg_mode,
  input  logic [DATA_WIDTH-1:0]   cfg_threshold,
  input  logic                    cfg_binarize,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sof,
  input  logic [9*DATA_WIDTH-1:0] in_window,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_sof,
  output logic [DATA_WIDTH-1:0]   out_pixel,
  output logic                    out_edge,
  output logic [CNT_WIDTH-1:0]    edge_count,
  output logic                    edge_count_valid
);

  localparam int W  = DATA_WIDTH;
  // Signed gradient width: a Sobel sum is at most 4*(2^W-1), so W+3 bits plus headroom.
  localparam int GW = W + 4;
  // |gx|+|gy| needs one bit more than each magnitude.
  localparam int SW = W + 5;

  localparam logic [W-1:0]         PIX_MAX = {W{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    MODE_FWD     = 2'd0,
    MODE_ROBERTS = 2'd1,
    MODE_PREWITT = 2'd2,
    MODE_SOBEL   = 2'd3
  } mode_e;

  typedef struct packed {
    mode_e        mode;
    logic [W-1:0] thr;
    logic         bin;
  } cfg_t;

  // ------------------------------------------------------------------
  // Handshake
  // ------------------------------------------------------------------
  logic advance;
  logic in_hs;
  logic out_hs;

  // ------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------
  cfg_t                  act_cfg_q, act_cfg_d;

  logic                  s1_vld_q, s1_vld_d;
  logic                  s1_sof_q, s1_sof_d;
  cfg_t                  s1_cfg_q, s1_cfg_d;
  logic signed [GW-1:0]  s1_gx_q, s1_gx_d;
  logic signed [GW-1:0]  s1_gy_q, s1_gy_d;

  logic                  s2_vld_q, s2_vld_d;
  logic                  s2_sof_q, s2_sof_d;
  logic [W-1:0]          s2_thr_q, s2_thr_d;
  logic                  s2_bin_q, s2_bin_d;
  logic [W-1:0]          s2_mag_q, s2_mag_d;

  logic                  out_vld_q, out_vld_d;
  logic                  out_sof_q, out_sof_d;
  logic [W-1:0]          out_pix_q, out_pix_d;
  logic                  out_edge_q, out_edge_d;

  logic [CNT_WIDTH-1:0]  run_cnt_q, run_cnt_d;
  logic                  seen_sof_q, seen_sof_d;
  logic [CNT_WIDTH-1:0]  edge_cnt_q, edge_cnt_d;
  logic                  edge_cnt_vld_q, edge_cnt_vld_d;

  // ------------------------------------------------------------------
  // Combinational datapath
  // ------------------------------------------------------------------
  cfg_t                  beat_cfg;
  logic signed [GW-1:0]  px [9];
  logic signed [GW-1:0]  gx_c, gy_c;
  logic [GW-1:0]         abs_gx, abs_gy;
  logic [SW-1:0]         grad_sum, grad_shr;
  logic [W-1:0]          mag_c;
  logic                  edge_c;
  logic [W-1:0]          pix_c;

  assign advance  = !out_vld_q || out_ready;
  assign in_ready = advance;
  assign in_hs    = in_valid && advance;
  assign out_hs   = out_vld_q && out_ready;

  // Config used by the incoming beat: a sof beat brings its own, others inherit the frame's.
  always_comb begin
    beat_cfg = act_cfg_q;
    if (in_sof) begin
      beat_cfg.mode = mode_e'(cfg_mode);
      beat_cfg.thr  = cfg_threshold;
      beat_cfg.bin  = cfg_binarize;
    end
  end

  // Unpack the window into zero-extended signed taps so kernel sums never wrap.
  always_comb begin
    for (int k = 0; k < 9; k++) begin
      px[k] = $signed({{(GW-W){1'b0}}, in_window[k*W +: W]});
    end
  end

  // Stage 1 kernels: horizontal and vertical gradients for the selected operator.
  always_comb begin
    gx_c = '0;
    gy_c = '0;
    case (beat_cfg.mode)
      MODE_FWD: begin
        gx_c = px[5] - px[4];
        gy_c = px[7] - px[4];
      end
      MODE_ROBERTS: begin
        gx_c = px[8] - px[4];
        gy_c = px[7] - px[5];
      end
      MODE_PREWITT: begin
        gx_c = (px[2] + px[5] + px[8]) - (px[0] + px[3] + px[6]);
        gy_c = (px[6] + px[7] + px[8]) - (px[0] + px[1] + px[2]);
      end
      default: begin
        gx_c = (px[2] + px[5] + px[5] + px[8]) - (px[0] + px[3] + px[3] + px[6]);
        gy_c = (px[6] + px[7] + px[7] + px[8]) - (px[0] + px[1] + px[1] + px[2]);
      end
    endcase
  end

  // Stage 2 magnitude: L1 norm, kernel-dependent normalising shift, saturate to pixel range.
  always_comb begin
    abs_gx   = s1_gx_q[GW-1] ? $unsigned(-s1_gx_q) : $unsigned(s1_gx_q);
    abs_gy   = s1_gy_q[GW-1] ? $unsigned(-s1_gy_q) : $unsigned(s1_gy_q);
    grad_sum = {1'b0, abs_gx} + {1'b0, abs_gy};
    if (s1_cfg_q.mode == MODE_FWD || s1_cfg_q.mode == MODE_ROBERTS) begin
      grad_shr = grad_sum >> 1;
    end else begin
      grad_shr = grad_sum >> 2;
    end
    if (grad_shr > {{(SW-W){1'b0}}, PIX_MAX}) begin
      mag_c = PIX_MAX;
    end else begin
      mag_c = grad_shr[W-1:0];
    end
  end

  // Stage 3 threshold and output formatting.
  always_comb begin
    edge_c = (s2_mag_q >= s2_thr_q);
    if (s2_bin_q) begin
      pix_c = edge_c ? PIX_MAX : '0;
    end else begin
      pix_c = s2_mag_q;
    end
  end

  // Pipeline next state: every stage holds unless the whole pipe advances.
  always_comb begin
    act_cfg_d  = act_cfg_q;
    s1_vld_d   = s1_vld_q;
    s1_sof_d   = s1_sof_q;
    s1_cfg_d   = s1_cfg_q;
    s1_gx_d    = s1_gx_q;
    s1_gy_d    = s1_gy_q;
    s2_vld_d   = s2_vld_q;
    s2_sof_d   = s2_sof_q;
    s2_thr_d   = s2_thr_q;
    s2_bin_d   = s2_bin_q;
    s2_mag_d   = s2_mag_q;
    out_vld_d  = out_vld_q;
    out_sof_d  = out_sof_q;
    out_pix_d  = out_pix_q;
    out_edge_d = out_edge_q;

    if (in_hs && in_sof) begin
      act_cfg_d = beat_cfg;
    end

    if (advance) begin
      s1_vld_d   = in_valid;
      s1_sof_d   = in_valid && in_sof;
      s1_cfg_d   = beat_cfg;
      s1_gx_d    = gx_c;
      s1_gy_d    = gy_c;

      s2_vld_d   = s1_vld_q;
      s2_sof_d   = s1_sof_q;
      s2_thr_d   = s1_cfg_q.thr;
      s2_bin_d   = s1_cfg_q.bin;
      s2_mag_d   = mag_c;

      out_vld_d  = s2_vld_q;
      out_sof_d  = s2_sof_q;
      out_pix_d  = pix_c;
      out_edge_d = edge_c;
    end
  end

  // Per-frame edge counting on accepted output beats; the report pulse lasts one cycle.
  always_comb begin
    run_cnt_d      = run_cnt_q;
    seen_sof_d     = seen_sof_q;
    edge_cnt_d     = edge_cnt_q;
    edge_cnt_vld_d = 1'b0;

    if (out_hs) begin
      if (out_sof_q) begin
        // Anything counted before the first sof is not a real frame and is dropped here.
        if (seen_sof_q) begin
          edge_cnt_d     = run_cnt_q;
          edge_cnt_vld_d = 1'b1;
        end
        seen_sof_d = 1'b1;
        run_cnt_d  = {{(CNT_WIDTH-1){1'b0}}, out_edge_q};
      end else if (out_edge_q && run_cnt_q != CNT_MAX) begin
        run_cnt_d = run_cnt_q + 1'b1;
      end
    end
  end

  // Pipeline registers; reset flushes in-flight beats and restores the default config.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      act_cfg_q  <= '0;
      s1_vld_q   <= 1'b0;
      s1_sof_q   <= 1'b0;
      s1_cfg_q   <= '0;
      s1_gx_q    <= '0;
      s1_gy_q    <= '0;
      s2_vld_q   <= 1'b0;
      s2_sof_q   <= 1'b0;
      s2_thr_q   <= '0;
      s2_bin_q   <= 1'b0;
      s2_mag_q   <= '0;
      out_vld_q  <= 1'b0;
      out_sof_q  <= 1'b0;
      out_pix_q  <= '0;
      out_edge_q <= 1'b0;
    end else begin
      act_cfg_q  <= act_cfg_d;
      s1_vld_q   <= s1_vld_d;
      s1_sof_q   <= s1_sof_d;
      s1_cfg_q   <= s1_cfg_d;
      s1_gx_q    <= s1_gx_d;
      s1_gy_q    <= s1_gy_d;
      s2_vld_q   <= s2_vld_d;
      s2_sof_q   <= s2_sof_d;
      s2_thr_q   <= s2_thr_d;
      s2_bin_q   <= s2_bin_d;
      s2_mag_q   <= s2_mag_d;
      out_vld_q  <= out_vld_d;
      out_sof_q  <= out_sof_d;
      out_pix_q  <= out_pix_d;
      out_edge_q <= out_edge_d;
    end
  end

  // Counter registers; reset discards any partial frame count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_cnt_q      <= '0;
      seen_sof_q     <= 1'b0;
      edge_cnt_q     <= '0;
      edge_cnt_vld_q <= 1'b0;
    end else begin
      run_cnt_q      <= run_cnt_d;
      seen_sof_q     <= seen_sof_d;
      edge_cnt_q     <= edge_cnt_d;
      edge_cnt_vld_q <= edge_cnt_vld_d;
    end
  end

  assign out_valid        = out_vld_q;
  assign out_sof          = out_sof_q;
  assign out_pixel        = out_pix_q;
  assign out_edge         = out_edge_q;
  assign edge_count       = edge_cnt_q;
  assign edge_count_valid = edge_cnt_vld_q;

endmodule

// File: tb/tb_edge_detect_stream.sv
// Directed bench for edge_detect_stream: kernels, saturation, thresholding, config capture,
// backpressure, per-frame edge counting and mid-frame reset, with hand-computed expectations.
`timescale 1ns/1ps
module tb_edge_detect_stream;
  localparam int W  = 8;
  localparam int CW = 24;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [1:0]    cfg_mode = '0;
  logic [W-1:0]  cfg_threshold = '0;
  logic          cfg_binarize = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_sof = 1'b0;
  logic [9*W-1:0] in_window = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          out_sof;
  logic [W-1:0]  out_pixel;
  logic          out_edge;
  logic [CW-1:0] edge_count;
  logic          edge_count_valid;

  always #5 clk = ~clk;

  edge_detect_stream #(.DATA_WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk              (clk),
    .rst              (rst),
    .cfg_mode         (cfg_mode),
    .cfg_threshold    (cfg_threshold),
    .cfg_binarize     (cfg_binarize),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_sof           (in_sof),
    .in_window        (in_window),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_sof          (out_sof),
    .out_pixel        (out_pixel),
    .out_edge         (out_edge),
    .edge_count       (edge_count),
    .edge_count_valid (edge_count_valid)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic [W-1:0] pix;
    logic         edg;
    logic         sof;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   pulse_n  = 0;
  int   last_cnt = 0;

  // Output scoreboard and edge-count pulse recorder, sampled away from the active edge.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("extra_beat", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("pixel", 32'(out_pixel), 32'(mon_e.pix));
        chk("edge",  32'(out_edge),  32'(mon_e.edg));
        chk("sof",   32'(out_sof),   32'(mon_e.sof));
      end
    end
    if (rst && edge_count_valid) begin
      pulse_n++;
      last_cnt = int'(edge_count);
    end
  end

  function automatic logic [9*W-1:0] mkw(input int v0, input int v1, input int v2,
                                         input int v3, input int v4, input int v5,
                                         input int v6, input int v7, input int v8);
    return {8'(v8), 8'(v7), 8'(v6), 8'(v5), 8'(v4), 8'(v3), 8'(v2), 8'(v1), 8'(v0)};
  endfunction

  // Present one beat (caller is at posedge+1) and hold it until accepted.
  task automatic send(input logic sof, input logic [1:0] mode, input logic [W-1:0] thr,
                      input logic bin, input logic [9*W-1:0] win,
                      input logic [W-1:0] ep, input logic ee);
    exp_t e;
    logic hs;
    logic done;
    e.pix = ep;
    e.edg = ee;
    e.sof = sof;
    exp_q.push_back(e);
    in_valid      = 1'b1;
    in_sof        = sof;
    cfg_mode      = mode;
    cfg_threshold = thr;
    cfg_binarize  = bin;
    in_window     = win;
    done = 1'b0;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      hs = in_ready;
      @(posedge clk);
      #1;
      if (hs) done = 1'b1;
    end
    if (!done) chk("handshake_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  // Wait for all expected beats to emerge, then let any count pulse land.
  task automatic drain();
    for (int t = 0; t < 100 && exp_q.size() != 0; t++) begin
      @(posedge clk);
      #1;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [9*W-1:0] win1;

  initial begin
    win1 = mkw(0, 0, 0, 0, 10, 50, 0, 30, 0);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_pixel", 32'(out_pixel), 32'd0);
    chk("rst_edge_count", 32'(edge_count), 32'd0);
    chk("rst_count_vld", 32'(edge_count_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Frame A: forward diff, exact 3-cycle latency. gx=40 gy=20 -> 60>>1 = 30.
    send(1'b1, 2'd0, 8'd0, 1'b0, win1, 8'd30, 1'b1);
    idle();
    @(negedge clk);
    chk("lat_c1_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("lat_c2_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("lat_c3_valid", 32'(out_valid), 32'd1);
    chk("lat_c3_pixel", 32'(out_pixel), 32'd30);
    @(posedge clk);
    #1;
    drain();
    chk("first_sof_no_pulse", 32'(pulse_n), 32'd0);

    // Frame B: Sobel. Right column 100 -> 400>>2 = 100; w5=w7=w8=255 -> 1530>>2 = 382 -> 255.
    send(1'b1, 2'd3, 8'd0, 1'b0, mkw(0, 0, 100, 0, 0, 100, 0, 0, 100), 8'd100, 1'b1);
    send(1'b0, 2'd3, 8'd0, 1'b0, mkw(0, 0, 0, 0, 0, 255, 0, 255, 255), 8'd255, 1'b1);
    idle();
    drain();
    chk("frameA_pulse_n", 32'(pulse_n), 32'd1);
    chk("frameA_count", 32'(last_cnt), 32'd1);

    // Frame C: Roberts, thr 40, binarised. w8=100 -> 50; w8=20 -> 10; w8=80 -> 40 (equal);
    // w5=100 -> |gy|=100 -> 50.
    send(1'b1, 2'd1, 8'd40, 1'b1, mkw(0, 0, 0, 0, 0, 0, 0, 0, 100), 8'd255, 1'b1);
    send(1'b0, 2'd1, 8'd40, 1'b1, mkw(0, 0, 0, 0, 0, 0, 0, 0, 20),  8'd0,   1'b0);
    send(1'b0, 2'd1, 8'd40, 1'b1, mkw(0, 0, 0, 0, 0, 0, 0, 0, 80),  8'd255, 1'b1);
    send(1'b0, 2'd1, 8'd40, 1'b1, mkw(0, 0, 0, 0, 0, 100, 0, 0, 0), 8'd255, 1'b1);
    idle();
    drain();
    chk("frameB_pulse_n", 32'(pulse_n), 32'd2);
    chk("frameB_count", 32'(last_cnt), 32'd2);

    // Frame D: mode 0, then a non-sof beat requesting Sobel/thr 200/binarise is ignored.
    send(1'b1, 2'd0, 8'd0,   1'b0, win1, 8'd30, 1'b1);
    send(1'b0, 2'd3, 8'd200, 1'b1, win1, 8'd30, 1'b1);
    idle();
    drain();
    chk("frameC_pulse_n", 32'(pulse_n), 32'd3);
    chk("frameC_count", 32'(last_cnt), 32'd3);

    // Frame E: sof switches to Sobel thr 20: win1 -> 160>>2 = 40; w5=v -> v>>1. 4 edges in 6 beats.
    send(1'b1, 2'd3, 8'd20, 1'b0, win1, 8'd40, 1'b1);
    send(1'b0, 2'd0, 8'd0, 1'b0, mkw(0, 0, 0, 0, 0, 100, 0, 0, 0), 8'd50,  1'b1);
    send(1'b0, 2'd0, 8'd0, 1'b0, mkw(0, 0, 0, 0, 0, 30,  0, 0, 0), 8'd15,  1'b0);
    send(1'b0, 2'd0, 8'd0, 1'b0, mkw(0, 0, 0, 0, 0, 40,  0, 0, 0), 8'd20,  1'b1);
    send(1'b0, 2'd0, 8'd0, 1'b0, mkw(0, 0, 0, 0, 0, 0,   0, 0, 0), 8'd0,   1'b0);
    send(1'b0, 2'd0, 8'd0, 1'b0, mkw(0, 0, 0, 0, 0, 255, 0, 0, 0), 8'd127, 1'b1);
    idle();
    drain();
    chk("frameD_pulse_n", 32'(pulse_n), 32'd4);
    chk("frameD_count", 32'(last_cnt), 32'd2);

    // Frame F: 10 back-to-back beats (mag = i+5) with out_ready low for cycles 4..8.
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          send(i == 0, 2'd0, 8'd0, 1'b0, mkw(0, 0, 0, 0, 0, 2*i + 10, 0, 0, 0), 8'(i + 5), 1'b1);
        end
        idle();
      end
      begin
        for (int c = 0; c < 16; c++) begin
          out_ready = !(c >= 4 && c <= 8);
          @(negedge clk);
          if (c == 6) begin
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_held_pixel", 32'(out_pixel), 32'd6);
          end
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();
    chk("frameE_pulse_n", 32'(pulse_n), 32'd5);
    chk("frameE_count", 32'(last_cnt), 32'd4);

    // Frame G: flat window, threshold 0 -> 0 >= 0 is an edge.
    send(1'b1, 2'd0, 8'd0, 1'b0, mkw(0, 0, 0, 0, 0, 0, 0, 0, 0), 8'd0, 1'b1);
    idle();
    drain();
    chk("frameF_pulse_n", 32'(pulse_n), 32'd6);
    chk("frameF_count", 32'(last_cnt), 32'd10);

    // Mid-frame reset with beats in flight.
    for (int i = 0; i < 4; i++) send(1'b0, 2'd0, 8'd0, 1'b0, win1, 8'd30, 1'b1);
    idle();
    #2;
    rst = 1'b0;
    exp_q.delete();
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_edge_count", 32'(edge_count), 32'd0);
    chk("midrst_count_vld", 32'(edge_count_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // After reset: pre-sof beats use default mode 0 even when Sobel is requested, and are not counted.
    send(1'b0, 2'd3, 8'd0, 1'b0, win1, 8'd30, 1'b1);
    send(1'b0, 2'd3, 8'd0, 1'b0, win1, 8'd30, 1'b1);
    send(1'b1, 2'd0, 8'd0, 1'b0, win1, 8'd30, 1'b1);
    send(1'b0, 2'd0, 8'd0, 1'b0, mkw(0, 0, 0, 0, 0, 0, 0, 0, 0), 8'd0, 1'b1);
    idle();
    drain();
    chk("postrst_no_pulse", 32'(pulse_n), 32'd6);
    send(1'b1, 2'd0, 8'd0, 1'b0, win1, 8'd30, 1'b1);
    idle();
    drain();
    chk("postrst_pulse_n", 32'(pulse_n), 32'd7);
    chk("postrst_count", 32'(last_cnt), 32'd2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
